// File: rtl/fg_pkg.sv
// Shared definitions for the function generator configuration loader:
// state encoding, bus width and configuration field layout.
package fg_pkg;

   localparam int CONFIG_REG_BITWIDTH = 56;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RECEIVE = 2'd1,
      ST_PENDING = 2'd2,
      ST_COMMIT  = 2'd3
   } fg_state_e;

   // Field LSB positions inside the 56-bit configuration word.
   localparam int CS_MODE_POS     = 55;
   localparam int WAVE_MODE_POS   = 48;
   localparam int WAVE_MODE_W     = 7;
   localparam int PRESCALER_POS   = 32;
   localparam int PRESCALER_W     = 16;
   localparam int AMPLITUDE_POS   = 16;
   localparam int AMPLITUDE_W     = 16;
   localparam int OFFSET_POS      = 0;
   localparam int OFFSET_W        = 16;

   function automatic logic [CONFIG_REG_BITWIDTH-1:0] pack_cr(
      input logic                   cs_mode,
      input logic [WAVE_MODE_W-1:0] wave_mode,
      input logic [PRESCALER_W-1:0] prescaler,
      input logic [AMPLITUDE_W-1:0] amplitude,
      input logic [OFFSET_W-1:0]    offset
   );
      logic [CONFIG_REG_BITWIDTH-1:0] w;
      w = '0;
      w[CS_MODE_POS]                    = cs_mode;
      w[WAVE_MODE_POS +: WAVE_MODE_W]   = wave_mode;
      w[PRESCALER_POS +: PRESCALER_W]   = prescaler;
      w[AMPLITUDE_POS +: AMPLITUDE_W]   = amplitude;
      w[OFFSET_POS +: OFFSET_W]         = offset;
      return w;
   endfunction

endpackage

// File: rtl/fg_timeout_counter.sv
// Inter-byte idle counter; expire_o is asserted during the enabled cycle
// that completes TIMEOUT_CYCLES consecutive idle clocks.
module fg_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = enable_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fg_config_loader.sv
// Byte-serial loader for the function generator configuration bus: assembles
// an MSB-first frame into a shadow register and commits it atomically.
//
// state   | meaning
// IDLE    | waiting for frameStart_i
// RECEIVE | collecting frame bytes, idle timeout armed
// PENDING | full frame held, waiting for the generator sample strobe
// COMMIT  | one cycle: shadow copied to CR_bus_o
module fg_config_loader #(
   parameter int                             CONFIG_REG_BITWIDTH = fg_pkg::CONFIG_REG_BITWIDTH,
   parameter int                             TIMEOUT_CYCLES      = 255,
   parameter bit                             SYNC_COMMIT         = 1'b1,
   parameter logic [CONFIG_REG_BITWIDTH-1:0] RESET_VALUE         = '0
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [7:0]                     data_i,
   input  logic                           dataValid_STRB_i,
   input  logic                           frameStart_i,
   input  logic                           sampleStrb_i,
   input  logic                           clearErr_i,
   output logic [CONFIG_REG_BITWIDTH-1:0] CR_bus_o,
   output logic                           crUpdate_STRB_o,
   output logic                           busy_o,
   output logic                           error_o
);

   import fg_pkg::*;

   localparam int NBYTES = CONFIG_REG_BITWIDTH / 8;
   localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   fg_state_e                      state_q, state_d;
   logic [IDXW-1:0]                idx_q, idx_d, wr_idx;
   logic [CONFIG_REG_BITWIDTH-1:0] shadow_q, shadow_d;
   logic [CONFIG_REG_BITWIDTH-1:0] cr_q, cr_d;
   logic                           upd_q, upd_d;
   logic                           err_q, err_d;
   logic                           err_set, start_frame, do_write;
   logic                           tmo_clr, tmo_en, tmo_expire;

   fg_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (tmo_clr),
      .enable_i(tmo_en),
      .expire_o(tmo_expire)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      shadow_d    = shadow_q;
      cr_d        = cr_q;
      upd_d       = 1'b0;
      err_set     = 1'b0;
      start_frame = 1'b0;
      do_write    = 1'b0;
      wr_idx      = idx_q;
      tmo_clr     = 1'b1;
      tmo_en      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (frameStart_i) begin
               start_frame = 1'b1;
            end else if (dataValid_STRB_i) begin
               err_set = 1'b1;
            end
         end
         ST_RECEIVE: begin
            if (frameStart_i) begin
               start_frame = 1'b1;
            end else if (dataValid_STRB_i) begin
               do_write = 1'b1;
            end else begin
               tmo_clr = 1'b0;
               tmo_en  = 1'b1;
               if (tmo_expire) begin
                  state_d  = ST_IDLE;
                  shadow_d = '0;
                  idx_d    = '0;
                  err_set  = 1'b1;
               end
            end
         end
         ST_PENDING: begin
            if (frameStart_i) begin
               start_frame = 1'b1;
            end else begin
               if (dataValid_STRB_i) begin
                  err_set = 1'b1;
               end
               if (sampleStrb_i) begin
                  state_d = ST_COMMIT;
               end
            end
         end
         ST_COMMIT: begin
            // The commit uses shadow_q, so a frame starting this cycle may
            // overwrite the shadow without disturbing the committed word.
            cr_d    = shadow_q;
            upd_d   = 1'b1;
            state_d = ST_IDLE;
            if (frameStart_i) begin
               start_frame = 1'b1;
            end else if (dataValid_STRB_i) begin
               err_set = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (start_frame) begin
         state_d  = ST_RECEIVE;
         shadow_d = '0;
         idx_d    = '0;
         wr_idx   = '0;
         do_write = dataValid_STRB_i;
      end

      if (do_write) begin
         for (int k = 0; k < NBYTES; k++) begin
            if (wr_idx == IDXW'(k)) begin
               shadow_d[CONFIG_REG_BITWIDTH-1-8*k -: 8] = data_i;
            end
         end
         if (wr_idx == IDXW'(NBYTES - 1)) begin
            idx_d = '0;
            if (SYNC_COMMIT) begin
               state_d = ST_PENDING;
            end else begin
               state_d = ST_COMMIT;
            end
         end else begin
            idx_d = wr_idx + IDXW'(1);
         end
      end

      err_d = err_set | (err_q & ~clearErr_i);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         shadow_q <= '0;
         cr_q     <= RESET_VALUE;
         upd_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         cr_q     <= cr_d;
         upd_q    <= upd_d;
         err_q    <= err_d;
      end
   end

   assign CR_bus_o        = cr_q;
   assign crUpdate_STRB_o = upd_q;
   assign error_o         = err_q;
   assign busy_o          = (state_q == ST_RECEIVE) || (state_q == ST_PENDING);

endmodule

// File: tb/tb_fg_config_loader.sv
// Bench for fg_config_loader: an immediate-commit and a sample-aligned instance
// share stimulus and are compared every cycle against a frame-level model.
module tb_fg_config_loader;
   import fg_pkg::*;

   localparam int W   = 56;
   localparam int NB  = W / 8;
   localparam int TMO = 4;
   localparam logic [W-1:0] RV_A = '0;
   localparam logic [W-1:0] RV_B = 56'hA5_0000_0000_005A;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst = 1'b1;
   logic         fs  = 1'b0;
   logic         dv  = 1'b0;
   logic         ss  = 1'b0;
   logic         ce  = 1'b0;
   logic [7:0]   data = '0;

   logic [W-1:0] cr_a, cr_b;
   logic         upd_a, upd_b, busy_a, busy_b, err_a, err_b;

   fg_config_loader #(
      .CONFIG_REG_BITWIDTH(W), .TIMEOUT_CYCLES(TMO), .SYNC_COMMIT(1'b0), .RESET_VALUE(RV_A)
   ) dut_a (
      .clk_i(clk), .rst_i(rst), .data_i(data), .dataValid_STRB_i(dv),
      .frameStart_i(fs), .sampleStrb_i(ss), .clearErr_i(ce),
      .CR_bus_o(cr_a), .crUpdate_STRB_o(upd_a), .busy_o(busy_a), .error_o(err_a)
   );

   fg_config_loader #(
      .CONFIG_REG_BITWIDTH(W), .TIMEOUT_CYCLES(TMO), .SYNC_COMMIT(1'b1), .RESET_VALUE(RV_B)
   ) dut_b (
      .clk_i(clk), .rst_i(rst), .data_i(data), .dataValid_STRB_i(dv),
      .frameStart_i(fs), .sampleStrb_i(ss), .clearErr_i(ce),
      .CR_bus_o(cr_b), .crUpdate_STRB_o(upd_b), .busy_o(busy_b), .error_o(err_b)
   );

   int checks = 0;
   int errors = 0;
   int pulses_a = 0;
   int pulses_b = 0;

   // Frame-level model: index 0 mirrors dut_a, index 1 mirrors dut_b.
   logic [W-1:0] m_cr[2], m_word[2], m_acc[2];
   bit           m_upd[2], m_err[2], m_in[2], m_await[2], m_cnow[2];
   int           m_cnt[2], m_idle[2];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_push(input int i, input bit sync);
      m_acc[i] = {m_acc[i][W-9:0], data};
      m_cnt[i]++;
      if (m_cnt[i] == NB) begin
         m_in[i]   = 1'b0;
         m_word[i] = m_acc[i];
         m_cnt[i]  = 0;
         if (sync) m_await[i] = 1'b1;
         else      m_cnow[i]  = 1'b1;
      end
   endtask

   task automatic model_step(input int i, input bit sync, input logic [W-1:0] rv);
      bit set_e;
      if (rst) begin
         m_cr[i] = rv;  m_upd[i] = 0; m_err[i] = 0; m_in[i] = 0; m_await[i] = 0;
         m_cnow[i] = 0; m_cnt[i] = 0; m_idle[i] = 0; m_acc[i] = '0;
      end else begin
         set_e    = 1'b0;
         m_upd[i] = 1'b0;
         if (m_cnow[i]) begin
            m_cr[i]   = m_word[i];
            m_upd[i]  = 1'b1;
            m_cnow[i] = 1'b0;
         end
         if (m_await[i] && ss && !fs) begin
            m_await[i] = 1'b0;
            m_cnow[i]  = 1'b1;
         end
         if (fs) begin
            m_in[i] = 1'b1; m_await[i] = 1'b0; m_cnt[i] = 0; m_idle[i] = 0; m_acc[i] = '0;
            if (dv) model_push(i, sync);
         end else if (dv) begin
            if (m_in[i]) begin
               m_idle[i] = 0;
               model_push(i, sync);
            end else begin
               set_e = 1'b1;
            end
         end else if (m_in[i]) begin
            m_idle[i]++;
            if (m_idle[i] == TMO) begin
               m_in[i] = 1'b0;
               set_e   = 1'b1;
            end
         end
         if (set_e)   m_err[i] = 1'b1;
         else if (ce) m_err[i] = 1'b0;
      end
   endtask

   // One clock: advance the model with the inputs presented, then compare.
   task automatic cycle();
      @(posedge clk);
      model_step(0, 1'b0, RV_A);
      model_step(1, 1'b1, RV_B);
      #1;
      chk ("cr_a",   cr_a,   m_cr[0]);
      chk1("upd_a",  upd_a,  m_upd[0]);
      chk1("busy_a", busy_a, m_in[0] | m_await[0]);
      chk1("err_a",  err_a,  m_err[0]);
      chk ("cr_b",   cr_b,   m_cr[1]);
      chk1("upd_b",  upd_b,  m_upd[1]);
      chk1("busy_b", busy_b, m_in[1] | m_await[1]);
      chk1("err_b",  err_b,  m_err[1]);
      if (upd_a === 1'b1) pulses_a++;
      if (upd_b === 1'b1) pulses_b++;
   endtask

   task automatic step_in(input bit r, input bit f, input bit v, input logic [7:0] d,
                          input bit s, input bit c);
      rst = r; fs = f; dv = v; data = d; ss = s; ce = c;
      cycle();
   endtask

   logic [7:0]   f1[NB];
   logic [W-1:0] fb;

   initial begin
      f1 = '{8'hC1, 8'h10, 8'h20, 8'h00, 8'h40, 8'h40, 8'h7F};
      fb = pack_cr(1'b0, 7'h01, 16'h0203, 16'h0405, 16'h0607);

      step_in(1, 0, 0, 8'h00, 0, 0);
      step_in(1, 0, 0, 8'h00, 0, 0);
      chk ("rst_cr_a", cr_a, 56'h0);
      chk ("rst_cr_b", cr_b, 56'hA5_0000_0000_005A);
      chk1("rst_busy_a", busy_a, 1'b0);
      chk1("rst_err_a", err_a, 1'b0);
      chk1("rst_upd_a", upd_a, 1'b0);

      // Basic frame: immediate commit on dut_a, sample-aligned on dut_b
      pulses_a = 0; pulses_b = 0;
      for (int k = 0; k < NB; k++) step_in(0, k == 0, 1, f1[k], 0, 0);
      chk ("lat_cr_a_early", cr_a, 56'h0);
      chk1("pend_busy_b", busy_b, 1'b1);
      step_in(0, 0, 0, 8'h00, 0, 0);
      chk ("frame1_cr_a", cr_a, 56'hC1_1020_0040_407F);
      chk1("frame1_upd_a", upd_a, 1'b1);
      for (int k = 0; k < 18; k++) step_in(0, 0, 0, 8'h00, 0, 0);
      chk1("frame1_busy_a", busy_a, 1'b0);
      chki("frame1_pulses_a", pulses_a, 1);
      chk ("wait_cr_b", cr_b, 56'hA5_0000_0000_005A);
      step_in(0, 0, 0, 8'h00, 1, 0);
      chk ("sample_cr_b_hold", cr_b, 56'hA5_0000_0000_005A);
      step_in(0, 0, 0, 8'h00, 0, 0);
      chk ("frame1_cr_b", cr_b, 56'hC1_1020_0040_407F);
      chk1("frame1_upd_b", upd_b, 1'b1);
      step_in(0, 0, 0, 8'h00, 0, 0);
      chki("frame1_pulses_b", pulses_b, 1);

      // Timeout after three bytes
      step_in(0, 1, 1, 8'h11, 0, 0);
      step_in(0, 0, 1, 8'h22, 0, 0);
      step_in(0, 0, 1, 8'h33, 0, 0);
      for (int k = 0; k < TMO - 1; k++) step_in(0, 0, 0, 8'h00, 0, 0);
      chk1("tmo_busy_before", busy_a, 1'b1);
      chk1("tmo_err_before", err_a, 1'b0);
      step_in(0, 0, 0, 8'h00, 0, 0);
      chk1("tmo_busy_a", busy_a, 1'b0);
      chk1("tmo_err_a", err_a, 1'b1);
      chk1("tmo_err_b", err_b, 1'b1);
      chk ("tmo_cr_a", cr_a, 56'hC1_1020_0040_407F);
      step_in(0, 0, 0, 8'h00, 0, 1);
      chk1("clr_err_a", err_a, 1'b0);

      // Restart: partial frame A abandoned for frame B
      pulses_a = 0; pulses_b = 0;
      step_in(0, 1, 1, 8'hAA, 0, 0);
      step_in(0, 0, 1, 8'hBB, 0, 0);
      step_in(0, 0, 1, 8'hCC, 0, 0);
      step_in(0, 0, 1, 8'hDD, 0, 0);
      for (int k = 0; k < NB; k++) step_in(0, k == 0, 1, fb[W-1-8*k -: 8], 0, 0);
      step_in(0, 0, 0, 8'h00, 1, 0);
      chk ("restart_cr_a", cr_a, 56'h01020304050607);
      step_in(0, 0, 0, 8'h00, 0, 0);
      chk ("restart_cr_b", cr_b, 56'h01020304050607);
      step_in(0, 0, 0, 8'h00, 0, 0);
      chk1("restart_err_a", err_a, 1'b0);
      chki("restart_pulses_a", pulses_a, 1);
      chki("restart_pulses_b", pulses_b, 1);

      // Stray byte, then set and clear together
      step_in(0, 0, 1, 8'h5A, 0, 0);
      chk1("stray_err_a", err_a, 1'b1);
      chk ("stray_cr_a", cr_a, 56'h01020304050607);
      step_in(0, 0, 0, 8'h00, 0, 1);
      step_in(0, 0, 1, 8'h5B, 0, 0);
      step_in(0, 0, 1, 8'h5C, 0, 1);
      chk1("set_wins_err_a", err_a, 1'b1);
      step_in(0, 0, 0, 8'h00, 0, 1);
      chk1("cleared_err_a", err_a, 1'b0);

      // Reset at byte 5 of a frame
      pulses_a = 0; pulses_b = 0;
      for (int k = 0; k < 5; k++) step_in(0, k == 0, 1, f1[k], 0, 0);
      step_in(1, 0, 1, f1[5], 0, 0);
      chk ("midrst_cr_a", cr_a, 56'h0);
      chk ("midrst_cr_b", cr_b, 56'hA5_0000_0000_005A);
      chk1("midrst_busy_a", busy_a, 1'b0);
      chk1("midrst_upd_a", upd_a, 1'b0);
      for (int k = 0; k < 6; k++) step_in(0, 0, 0, 8'h00, k[0], 0);
      chki("midrst_pulses_a", pulses_a, 0);
      chki("midrst_pulses_b", pulses_b, 0);

      // Randomized traffic, two density regimes
      for (int k = 0; k < 4000; k++) begin
         step_in($urandom_range(0, 599) == 0,
                 $urandom_range(0, 15) == 0,
                 (k < 2000) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 1) != 0),
                 8'($urandom),
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 31) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
